commit_checker: RTL and testbench
=================================

# commit_checker

Hardware consumer of the CPU commit trace. It accepts a stream of expected retirement records from a trace source (ROM or FIFO loaded with the golden log) over a valid/ready handshake and buffers them in a small FIFO. It compares each record, in order, against the live retirement event from the execute stage: register write, memory store, or jump. It reports pass/fail, a match count and the first failing PC, so a run self-checks on the simulator or on an FPGA without a file system.

## Interface
- DEPTH, 4, expected-record FIFO depth; power of two, 2..16.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- exp_valid  in  1  expected record present.
- exp_ready  out  1  checker accepts record this cycle.
- exp_kind  in  2  0=REG write, 1=MEM store, 2=PC (jump), 3=reserved.
- exp_pc  in  16  PC of the retiring instruction.
- exp_addr  in  16  register index (REG) or memory address (MEM); ignored for PC.
- exp_data  in  16  written value (REG/MEM) or jump target (PC).
- exp_last  in  1  marks final record of the trace.
- ret_valid  in  1  one-cycle pulse per retired instruction.
- ret_kind, ret_pc, ret_addr, ret_data  in  2/16/16/16  live event, same encoding as exp_*.
- halt  in  1  CPU halt indication.
- done  out  1  checker reached PASS or FAIL.
- mismatch  out  1  sticky; set in FAIL.
- err_code  out  2  0=none, 1=field mismatch, 2=underrun (retire with empty FIFO), 3=overrun/early halt.
- match_cnt  out  16  number of matched retirements.
- fail_pc  out  16  ret_pc of the failing retirement; 0 for halt-caused failures.

## Operation
- States: RUN, PASS, FAIL. Reset enters RUN.
- FIFO: DEPTH entries of {kind, pc, addr, data, last}.
- exp_ready = (state==RUN) && !full && !last_seen. last_seen sets when a record with exp_last=1 is pushed.
- Push on exp_valid && exp_ready.
- RUN, ret_valid=1:
  - FIFO empty: go to FAIL, err_code=2.
  - Head matches: pop and increment match_cnt. If head.last=1, go to PASS.
  - Head differs: go to FAIL, err_code=1. The head is not popped.
- Match rule: kinds equal and pc equal, plus
  - REG/MEM: addr equal and data equal.
  - PC: data equal; addr ignored.
  - Kind 3 never matches.
- RUN, halt=1: evaluated after any same-cycle retirement. If the trace has not completed (no last record popped), go to FAIL, err_code=3, fail_pc=0.
- PASS, ret_valid=1: go to FAIL, err_code=3, fail_pc=ret_pc. halt in PASS is ignored.
- FAIL is terminal until reset; no further pushes, pops or counter changes.
- fail_pc captures ret_pc on every transition to FAIL caused by a retirement.
- match_cnt wraps from 0xFFFF to 0x0000.

## Timing
- Reset values: exp_ready=1 (FIFO empty), done=0, mismatch=0, err_code=0, match_cnt=0, fail_pc=0; FIFO empty; last_seen=0.
- exp_ready is combinational from registered state. A push and a pop in the same cycle leave the count unchanged.
- When the FIFO is full, exp_ready=0 even if a pop occurs that cycle; there is no full-bypass.
- There is no bypass from exp_* to the comparator. A record pushed in the same cycle it is needed is an underrun.
- A record pushed at edge N is comparable to a ret_valid sampled at edge N+1 or later.
- done, mismatch, err_code, match_cnt and fail_pc are registered. They reflect a retirement sampled at edge N after edge N.
- Reset asserted mid-run clears all state asynchronously, including FIFO contents; partially compared records are discarded.

## Configuration
- COMMIT_CHECK_DATA_EN defined: data fields are compared as above.
- COMMIT_CHECK_DATA_EN undefined: exp_data/ret_data are ignored for all kinds. Only kind, pc and addr (REG/MEM) are checked, i.e. control-flow and address-only checking. err_code=1 then covers only those fields.

## Test plan
- Push REG{pc=0000,addr=1,data=00AB}, then PC{pc=0002,data=0010,last}; retire both identically, then halt → done=1, mismatch=0, match_cnt=2, state PASS.
- Push MEM{pc=0004,addr=0100,data=1234}; retire MEM with data=1235 → mismatch=1, err_code=1, fail_pc=0004. With COMMIT_CHECK_DATA_EN undefined → match_cnt=1, no mismatch.
- ret_valid with empty FIFO at pc=0006 → err_code=2, fail_pc=0006. Same cycle exp_valid=1 → still underrun.
- Fill FIFO (DEPTH=4) with exp_valid held high → exp_ready=0 after 4 pushes. A retire + push in the same cycle is refused; the push is accepted on the next cycle.
- Push 3 records, last on the 3rd; retire 2, then halt → err_code=3, fail_pc=0000. Separately, after PASS, an extra retire at pc=0008 → err_code=3, fail_pc=0008.
- Assert rst_n=0 mid-run with FIFO holding 2 entries and match_cnt=5 → all outputs return to reset values immediately; a new trace then runs to PASS.

Source files
------------

// File: rtl/commit_checker.sv
// Commit-trace checker: buffers golden retirement records and compares them in order
// against live retirements. Define COMMIT_CHECK_DATA_EN to include data fields in the compare.
module commit_checker #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic [15:0] exp_pc,
  input  logic [15:0] exp_addr,
  input  logic [15:0] exp_data,
  input  logic        exp_last,
  input  logic        ret_valid,
  input  logic [1:0]  ret_kind,
  input  logic [15:0] ret_pc,
  input  logic [15:0] ret_addr,
  input  logic [15:0] ret_data,
  input  logic        halt,
  output logic        done,
  output logic        mismatch,
  output logic [1:0]  err_code,
  output logic [15:0] match_cnt,
  output logic [15:0] fail_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } rec_t;

  localparam logic [1:0] K_PC  = 2'd2;
  localparam logic [1:0] K_RSV = 2'd3;

  state_t        state_q, state_d;
  rec_t          mem_q [DEPTH];
  rec_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          last_seen_q, last_seen_d;
  logic [1:0]    err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   fpc_q, fpc_d;

  rec_t head;
  logic empty, full, push, pop, rec_match, data_ok;

  assign head      = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign exp_ready = (state_q == S_RUN) && !full && !last_seen_q;
  assign push      = exp_valid && exp_ready;

`ifdef COMMIT_CHECK_DATA_EN
  assign data_ok = (head.data == ret_data);
`else
  logic unused_data;
  assign unused_data = ^{head.data, ret_data};
  assign data_ok     = 1'b1;
`endif

  // PC-kind records carry the jump target in data; their addr is don't-care.
  assign rec_match = (head.kind == ret_kind) && (head.kind != K_RSV) &&
                     (head.pc == ret_pc) && data_ok &&
                     ((head.kind == K_PC) || (head.addr == ret_addr));

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_seen_d = last_seen_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    fpc_d       = fpc_q;
    pop         = 1'b0;

    case (state_q)
      S_RUN: begin
        if (ret_valid) begin
          if (empty) begin
            state_d = S_FAIL;
            err_d   = 2'd2;
            fpc_d   = ret_pc;
          end else if (rec_match) begin
            pop   = 1'b1;
            cnt_d = cnt_q + 16'd1;
            if (head.last) state_d = S_PASS;
          end else begin
            state_d = S_FAIL;
            err_d   = 2'd1;
            fpc_d   = ret_pc;
          end
        end
        // Halt is judged after any same-cycle retirement has been resolved.
        if (halt && state_d == S_RUN) begin
          state_d = S_FAIL;
          err_d   = 2'd3;
          fpc_d   = 16'h0000;
        end
      end
      S_PASS: begin
        if (ret_valid) begin
          state_d = S_FAIL;
          err_d   = 2'd3;
          fpc_d   = ret_pc;
        end
      end
      default: ;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = '{kind: exp_kind, pc: exp_pc, addr: exp_addr,
                          data: exp_data, last: exp_last};
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (exp_last) last_seen_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 2'd0;
      cnt_q       <= 16'h0000;
      fpc_q       <= 16'h0000;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      fpc_q       <= fpc_d;
    end
  end

  assign done      = (state_q != S_RUN);
  assign mismatch  = (state_q == S_FAIL);
  assign err_code  = err_q;
  assign match_cnt = cnt_q;
  assign fail_pc   = fpc_q;

endmodule

// File: tb/tb_commit_checker.sv
// Scoreboard bench for commit_checker: a queue-based trace model predicts the outputs
// after every clock edge and a monitor compares them on the following falling edge.
module tb_commit_checker;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } rec_t;

  typedef struct {
    string      tag;
    bit         ready, done, mism;
    bit [1:0]   err;
    bit [15:0]  cnt, fpc;
  } snap_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        exp_valid, exp_ready, exp_last, ret_valid, halt;
  logic [1:0]  exp_kind, ret_kind, err_code;
  logic [15:0] exp_pc, exp_addr, exp_data, ret_pc, ret_addr, ret_data;
  logic        done, mismatch;
  logic [15:0] match_cnt, fail_pc;

  commit_checker #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
    .exp_pc(exp_pc), .exp_addr(exp_addr), .exp_data(exp_data), .exp_last(exp_last),
    .ret_valid(ret_valid), .ret_kind(ret_kind), .ret_pc(ret_pc),
    .ret_addr(ret_addr), .ret_data(ret_data), .halt(halt),
    .done(done), .mismatch(mismatch), .err_code(err_code),
    .match_cnt(match_cnt), .fail_pc(fail_pc)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  snap_t sbq[$];
  string cur_tag = "init";

  // Reference model: 0=running, 1=passed, 2=failed
  rec_t      mq[$];
  int        mst;
  bit        mlast_seen;
  bit [1:0]  merr;
  bit [15:0] mcnt, mfpc;

  function automatic rec_t mk(bit [1:0] k, bit [15:0] pc, bit [15:0] a, bit [15:0] d, bit l);
    rec_t r;
    r.kind = k; r.pc = pc; r.addr = a; r.data = d; r.last = l;
    return r;
  endfunction

  function automatic bit rec_eq(rec_t e, rec_t r);
    if (e.kind == 2'd3 || e.kind != r.kind || e.pc != r.pc) return 0;
    if (e.kind != 2'd2 && e.addr != r.addr) return 0;
`ifdef COMMIT_CHECK_DATA_EN
    if (e.data != r.data) return 0;
`endif
    return 1;
  endfunction

  function automatic void model_reset();
    mq.delete(); mst = 0; mlast_seen = 0; merr = 0; mcnt = 0; mfpc = 0;
  endfunction

  function automatic snap_t model_snap(string tag);
    snap_t s;
    s.tag   = tag;
    s.ready = (mst == 0) && (mq.size() < DEPTH) && !mlast_seen;
    s.done  = (mst != 0);
    s.mism  = (mst == 2);
    s.err   = merr; s.cnt = mcnt; s.fpc = mfpc;
    return s;
  endfunction

  task automatic check(snap_t s);
    total++;
    if (exp_ready !== s.ready || done !== s.done || mismatch !== s.mism ||
        err_code !== s.err || match_cnt !== s.cnt || fail_pc !== s.fpc) begin
      bad++;
      $display("FAIL %s: got rdy=%0b done=%0b mis=%0b err=%0d cnt=%0d fpc=%h want rdy=%0b done=%0b mis=%0b err=%0d cnt=%0d fpc=%h",
               s.tag, exp_ready, done, mismatch, err_code, match_cnt, fail_pc,
               s.ready, s.done, s.mism, s.err, s.cnt, s.fpc);
    end
  endtask

  task automatic idle();
    exp_valid = 0; exp_kind = 0; exp_pc = 0; exp_addr = 0; exp_data = 0; exp_last = 0;
    ret_valid = 0; ret_kind = 0; ret_pc = 0; ret_addr = 0; ret_data = 0; halt = 0;
  endtask

  // One clock: drive inputs, advance the model, queue the expected post-edge outputs.
  task automatic step(bit ev, rec_t e, bit rv, rec_t r, bit h, output bit pushed, output bit popped);
    bit ready;
    int ost;
    @(negedge clk);
    exp_valid = ev; exp_kind = e.kind; exp_pc = e.pc; exp_addr = e.addr;
    exp_data = e.data; exp_last = e.last;
    ret_valid = rv; ret_kind = r.kind; ret_pc = r.pc; ret_addr = r.addr;
    ret_data = r.data; halt = h;
    ready  = (mst == 0) && (mq.size() < DEPTH) && !mlast_seen;
    pushed = ev && ready;
    popped = 0;
    ost    = mst;
    if (ost == 0 && rv) begin
      if (mq.size() == 0) begin mst = 2; merr = 2; mfpc = r.pc; end
      else if (rec_eq(mq[0], r)) begin
        popped = 1; mcnt++;
        if (mq[0].last) mst = 1;
        void'(mq.pop_front());
      end else begin mst = 2; merr = 1; mfpc = r.pc; end
    end else if (ost == 1 && rv) begin
      mst = 2; merr = 3; mfpc = r.pc;
    end
    if (ost == 0 && h && mst == 0) begin mst = 2; merr = 3; mfpc = 0; end
    if (pushed) begin
      mq.push_back(e);
      if (e.last) mlast_seen = 1;
    end
    @(posedge clk);
    sbq.push_back(model_snap(cur_tag));
  endtask

  task automatic st(bit ev, rec_t e, bit rv, rec_t r, bit h);
    bit p, q;
    step(ev, e, rv, r, h, p, q);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    idle();
    model_reset();
    #1 check(model_snap(tag));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_run(int n);
    rec_t gold[$];
    rec_t e, r;
    int pi, ri;
    bit ev, rv, h, pushed, popped;
    for (int i = 0; i < n; i++) begin
      e = mk(($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), 16'(i * 2),
             16'($urandom), 16'($urandom), i == n - 1);
      gold.push_back(e);
    end
    pi = 0; ri = 0;
    for (int cyc = 0; cyc < n * 6 + 10; cyc++) begin
      ev = (pi < n) && ($urandom_range(0, 1) == 1);
      e  = (pi < n) ? gold[pi] : '0;
      rv = ($urandom_range(0, 2) == 0);
      r  = (ri < n) ? gold[ri] : mk(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 16'($urandom), 0);
      if ($urandom_range(0, 15) == 0) r.pc = r.pc ^ 16'h0001;
      if ($urandom_range(0, 15) == 0) r.data = r.data ^ 16'h0001;
      h  = (ri >= n && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      step(ev, e, rv, r, h, pushed, popped);
      if (pushed) pi++;
      if (popped) ri++;
      if (mst == 2) break;
    end
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        s = sbq.pop_front();
        check(s);
      end
    end
  end

  initial begin : driver
    rec_t z, r0, r1, rr[7];
    z = '0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check(model_snap("reset_values"));

    cur_tag = "basic_pass";
    r0 = mk(2'd0, 16'h0000, 16'h0001, 16'h00AB, 0);
    r1 = mk(2'd2, 16'h0002, 16'h0000, 16'h0010, 1);
    st(1, r0, 0, z, 0);
    st(1, r1, 0, z, 0);
    st(0, z, 1, r0, 0);
    st(0, z, 1, r1, 0);
    st(0, z, 0, z, 1);
    st(0, z, 0, z, 0);

    do_reset("reset_after_pass");
    cur_tag = "mem_data_diff";
    st(1, mk(2'd1, 16'h0004, 16'h0100, 16'h1234, 0), 0, z, 0);
    st(0, z, 0, z, 0);
    st(0, z, 1, mk(2'd1, 16'h0004, 16'h0100, 16'h1235, 0), 0);
    st(0, z, 0, z, 0);

    do_reset("reset_after_mem");
    cur_tag = "underrun";
    st(1, mk(2'd0, 16'h0006, 16'h0002, 16'h0003, 0), 1, mk(2'd0, 16'h0006, 16'h0002, 16'h0003, 0), 0);
    st(1, mk(2'd0, 16'h0008, 16'h0002, 16'h0003, 0), 0, z, 0);

    do_reset("reset_after_underrun");
    cur_tag = "fill_full";
    for (int i = 0; i < 7; i++) rr[i] = mk(2'd0, 16'(i * 2), 16'(i), 16'(16'h0040 + i), 0);
    for (int i = 0; i < 5; i++) st(1, rr[i < 4 ? i : 4], 0, z, 0);
    cur_tag = "full_retire_push";
    st(1, rr[4], 1, rr[0], 0);
    st(1, rr[4], 0, z, 0);
    st(0, z, 0, z, 0);

    do_reset("reset_after_fill");
    cur_tag = "early_halt";
    st(1, mk(2'd0, 16'h0000, 16'h0001, 16'h0011, 0), 0, z, 0);
    st(1, mk(2'd1, 16'h0002, 16'h0200, 16'h0022, 0), 0, z, 0);
    st(1, mk(2'd2, 16'h0004, 16'h0000, 16'h0030, 1), 0, z, 0);
    st(0, z, 1, mk(2'd0, 16'h0000, 16'h0001, 16'h0011, 0), 0);
    st(0, z, 1, mk(2'd1, 16'h0002, 16'h0200, 16'h0022, 0), 0);
    st(0, z, 0, z, 1);

    do_reset("reset_after_halt");
    cur_tag = "retire_after_pass";
    st(1, mk(2'd2, 16'h0006, 16'h0000, 16'h0050, 1), 0, z, 0);
    st(0, z, 1, mk(2'd2, 16'h0006, 16'h0000, 16'h0050, 0), 0);
    st(0, z, 1, mk(2'd0, 16'h0008, 16'h0001, 16'h0001, 0), 0);

    do_reset("reset_before_midrun");
    cur_tag = "midrun";
    for (int i = 0; i < 4; i++) st(1, rr[i], 0, z, 0);
    for (int i = 0; i < 3; i++) st(0, z, 1, rr[i], 0);
    for (int i = 4; i < 7; i++) st(1, rr[i], 0, z, 0);
    for (int i = 3; i < 5; i++) st(0, z, 1, rr[i], 0);
    do_reset("async_reset_midrun");
    cur_tag = "pass_after_reset";
    st(1, r0, 0, z, 0);
    st(1, r1, 0, z, 0);
    st(0, z, 1, r0, 0);
    st(0, z, 1, r1, 0);

    for (int k = 0; k < 30; k++) begin
      do_reset("reset_random");
      cur_tag = $sformatf("random_%0d", k);
      rand_run($urandom_range(1, 12));
    end

    @(negedge clk);
    idle();
    repeat (2) @(negedge clk);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
